sha2_hash_state: RTL
====================

# sha2_hash_state

Parametrised SHA-2 intermediate-hash register: holds the eight chaining words H0..H7, loads the mode-specific initial value, and adds the compression round's working variables a..h into H once per message block. It also streams the truncated digest out one word per cycle over a valid/ready port. It sits between the round datapath (source of a..h) and the digest consumer, and supports SHA-224/256 (32-bit words) and SHA-384/512 (64-bit words).

## Interface
- WORD_W, 32, word width; legal values 32 (SHA-224/256) or 64 (SHA-384/512).
- CNT_W, 16, width of the processed-block counter.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- init  in  1  single-cycle pulse; loads IV for `mode` and arms the block.
- mode  in  1  0: SHA-256 (WORD_W=32) / SHA-512 (WORD_W=64); 1: SHA-224 / SHA-384. Sampled only on `init`.
- upd_valid  in  1  working variables on `work` are valid.
- upd_ready  out  1  block accepts an update this cycle.
- work  in  8*WORD_W  {a,b,c,d,e,f,g,h}; a in the MSBs.
- H  out  8*WORD_W  current chaining value {H0..H7}; H0 in the MSBs.
- blk_count  out  CNT_W  updates accepted since last `init`; saturates at all-ones.
- rd_start  in  1  request digest readout.
- dout  out  WORD_W  digest word, H0 first.
- dout_valid  out  1  `dout` holds a valid word.
- dout_ready  in  1  consumer accepts `dout` this cycle.
- dout_last  out  1  high with the final digest word.

## Operation
- States: EMPTY, READY, READOUT.
- Reset: state EMPTY; H=0, blk_count=0, upd_ready=0, dout=0, dout_valid=0, dout_last=0, latched mode=0.
- EMPTY: only `init` acts; `upd_valid` and `rd_start` are ignored.
- `init` (any state): H <= IV(WORD_W, mode), blk_count <= 0, mode latched, state READY. It aborts a readout in progress (dout_valid drops the next cycle). `init` has priority over update and readout in the same cycle.
- READY: upd_ready=1. On upd_valid: each Hi <= Hi + work_i mod 2^WORD_W (no carries between words); blk_count++ (saturating). Back-to-back updates are allowed, one per cycle.
- READY with rd_start and no upd_valid: state READOUT, word index <= 0. If upd_valid and rd_start are high together, the update wins and rd_start is dropped; the requester must re-assert it.
- READOUT: upd_ready=0. dout = H[idx], dout_valid=1. On dout_ready, idx++. dout_last is high when idx == N-1.
  - N = 8 for SHA-256/512, 7 for SHA-224, 6 for SHA-384.
  - When the last word is accepted: state READY; H is unchanged, so re-reading or further updates are allowed.
- rd_start during READOUT is ignored.

## Timing
- `init` at edge T: new H and upd_ready=1 are visible after T.
- Update latency is 1 cycle: H reflects the sum in the cycle after acceptance.
- Readout: rd_start accepted at edge T; word 0 is on dout with dout_valid=1 from T+1.
  - dout is registered and held stable while dout_ready=0.
  - Throughput is one word per cycle while dout_ready=1.
  - After the last handshake, dout_valid=0 and upd_ready=1 in the following cycle.
- Reset asserted mid-readout or mid-update clears to the reset state at that edge.

## Structure
- Package `sha2_pkg`:
  - IV constants for SHA-224, SHA-256, SHA-384 and SHA-512;
  - mode encoding;
  - digest word counts (7, 8, 6, 8);
  - state enum.
- Sub-module `sha2_digest_serializer`: owns READOUT indexing, the dout register and valid/ready/last, fed with H and N.
- Top level holds H, the adders, blk_count and the state machine.

## Test plan
- WORD_W=32, init with mode=0: H0=32'h6a09e667 and H7=32'h5be0cd19 in the next cycle; blk_count=0.
- WORD_W=32, init, then update work={32'h1,0,0,0,0,0,0,32'hFFFFFFFF} (a=1, h=all-ones): H0=32'h6a09e668 and H7=32'h5be0cd18 (wrap, no carry into H6); blk_count=1.
- WORD_W=32, mode=1 (SHA-224), rd_start with dout_ready toggling 1/0: dout sequence starts 32'hc1059ed8; exactly 7 words; dout stable while stalled; dout_last on word 7; back to READY.
- WORD_W=64, mode=1 (SHA-384):
  - init then readout: first word 64'hcbbb9d5dc1059ed8; 6 words.
  - mode=0 init: H0=64'h6a09e667f3bcc908.
- Simultaneous events:
  - upd_valid+rd_start in READY: only the update applies, no dout_valid.
  - init during READOUT: dout_valid=0 the next cycle and H=IV.
- Reset asserted mid-readout: all outputs return to their reset values. update or rd_start before any init: ignored, H stays 0.

Source files
------------

// File: rtl/sha2_pkg.sv
// Shared SHA-2 constants for the chaining-value register: initial hash values,
// mode encoding, digest lengths in words, and the controller state encoding.
package sha2_pkg;

   typedef enum logic {
      MODE_FULL  = 1'b0,  // SHA-256 / SHA-512
      MODE_TRUNC = 1'b1   // SHA-224 / SHA-384
   } mode_e;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_READY   = 2'd1,
      ST_READOUT = 2'd2
   } state_e;

   localparam logic [3:0] DIGEST_WORDS_224 = 4'd7;
   localparam logic [3:0] DIGEST_WORDS_256 = 4'd8;
   localparam logic [3:0] DIGEST_WORDS_384 = 4'd6;
   localparam logic [3:0] DIGEST_WORDS_512 = 4'd8;

   // H0 sits in the most significant word of each constant.
   localparam logic [255:0] IV_SHA224 = {
      32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
   localparam logic [255:0] IV_SHA256 = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   localparam logic [511:0] IV_SHA384 = {
      64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
      64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4};
   localparam logic [511:0] IV_SHA512 = {
      64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
      64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};

   function automatic logic [3:0] digest_words(input logic wide, input mode_e m);
      if (m == MODE_FULL) return wide ? DIGEST_WORDS_512 : DIGEST_WORDS_256;
      return wide ? DIGEST_WORDS_384 : DIGEST_WORDS_224;
   endfunction

endpackage

// File: rtl/sha2_hash_state_if.sv
// Bundle of control, update and digest-stream signals between the hash-state
// block (slave) and the round datapath / digest consumer (master).
interface sha2_hash_state_if #(
   parameter int WORD_W = 32,
   parameter int CNT_W  = 16
);
   logic                  init;
   logic                  mode;
   logic                  upd_valid;
   logic                  upd_ready;
   logic [8*WORD_W-1:0]   work;
   logic [8*WORD_W-1:0]   H;
   logic [CNT_W-1:0]      blk_count;
   logic                  rd_start;
   logic [WORD_W-1:0]     dout;
   logic                  dout_valid;
   logic                  dout_ready;
   logic                  dout_last;

   modport slave (
      input  init, mode, upd_valid, work, rd_start, dout_ready,
      output upd_ready, H, blk_count, dout, dout_valid, dout_last
   );

   modport master (
      output init, mode, upd_valid, work, rd_start, dout_ready,
      input  upd_ready, H, blk_count, dout, dout_valid, dout_last
   );
endinterface

// File: rtl/sha2_digest_serializer.sv
// Streams the first n_words words of the chaining value (H0 first) over a
// registered valid/ready port; done pulses on the final handshake.
module sha2_digest_serializer #(
   parameter int WORD_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [8*WORD_W-1:0] h_in,
   input  logic [3:0]          n_words,
   input  logic                start,
   input  logic                abort,
   input  logic                dout_ready,
   output logic [WORD_W-1:0]   dout,
   output logic                dout_valid,
   output logic                dout_last,
   output logic                done
);

   logic [WORD_W-1:0] words [8];
   logic [2:0]        idx_q, idx_d, idx_next;
   logic [WORD_W-1:0] dout_q, dout_d;
   logic              valid_q, valid_d;
   logic              last_q, last_d;

   for (genvar gi = 0; gi < 8; gi++) begin : g_words
      assign words[gi] = h_in[(7-gi)*WORD_W +: WORD_W];
   end

   assign idx_next = idx_q + 3'd1;

   // h_in is frozen during a readout, so the next word can be preloaded on each handshake.
   always_comb begin
      idx_d   = idx_q;
      dout_d  = dout_q;
      valid_d = valid_q;
      last_d  = last_q;
      done    = 1'b0;
      if (abort) begin
         idx_d   = 3'd0;
         valid_d = 1'b0;
         last_d  = 1'b0;
      end else if (start) begin
         idx_d   = 3'd0;
         dout_d  = words[0];
         valid_d = 1'b1;
         last_d  = (n_words == 4'd1);
      end else if (valid_q && dout_ready) begin
         if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done    = 1'b1;
         end else begin
            idx_d  = idx_next;
            dout_d = words[idx_next];
            last_d = ({1'b0, idx_next} == (n_words - 4'd1));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q   <= 3'd0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign dout_last  = last_q;

endmodule

// File: rtl/sha2_hash_state.sv
// SHA-2 chaining-value register: IV load, per-block word-wise accumulation of
// the working variables, block counting, and truncated digest readout.
module sha2_hash_state
   import sha2_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   sha2_hash_state_if.slave  bus
);

   state_e              state_q, state_d;
   logic [8*WORD_W-1:0] h_q, h_d, h_sum;
   logic [CNT_W-1:0]    blk_count_q, blk_count_d;
   mode_e               mode_q, mode_d;
   logic [8*WORD_W-1:0] iv_full, iv_trunc;
   logic                ser_start, ser_abort, ser_done;

   if (WORD_W == 64) begin : g_iv64
      assign iv_full  = IV_SHA512;
      assign iv_trunc = IV_SHA384;
   end else begin : g_iv32
      assign iv_full  = IV_SHA256;
      assign iv_trunc = IV_SHA224;
   end

   // Independent adders per word: no carry crosses a word boundary.
   for (genvar gi = 0; gi < 8; gi++) begin : g_add
      assign h_sum[gi*WORD_W +: WORD_W] = h_q[gi*WORD_W +: WORD_W] + bus.work[gi*WORD_W +: WORD_W];
   end

   always_comb begin
      state_d     = state_q;
      h_d         = h_q;
      blk_count_d = blk_count_q;
      mode_d      = mode_q;
      ser_start   = 1'b0;
      ser_abort   = 1'b0;
      if (bus.init) begin
         mode_d      = mode_e'(bus.mode);
         h_d         = bus.mode ? iv_trunc : iv_full;
         blk_count_d = '0;
         state_d     = ST_READY;
         ser_abort   = 1'b1;
      end else begin
         case (state_q)
            ST_READY: begin
               if (bus.upd_valid) begin
                  h_d         = h_sum;
                  blk_count_d = (blk_count_q == '1) ? blk_count_q : blk_count_q + CNT_W'(1);
               end else if (bus.rd_start) begin
                  state_d   = ST_READOUT;
                  ser_start = 1'b1;
               end
            end
            ST_READOUT: begin
               if (ser_done) state_d = ST_READY;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_EMPTY;
         h_q         <= '0;
         blk_count_q <= '0;
         mode_q      <= MODE_FULL;
      end else begin
         state_q     <= state_d;
         h_q         <= h_d;
         blk_count_q <= blk_count_d;
         mode_q      <= mode_d;
      end
   end

   sha2_digest_serializer #(.WORD_W(WORD_W)) u_ser (
      .clk        (clk),
      .reset      (reset),
      .h_in       (h_q),
      .n_words    (digest_words(WORD_W == 64, mode_q)),
      .start      (ser_start),
      .abort      (ser_abort),
      .dout_ready (bus.dout_ready),
      .dout       (bus.dout),
      .dout_valid (bus.dout_valid),
      .dout_last  (bus.dout_last),
      .done       (ser_done)
   );

   assign bus.H         = h_q;
   assign bus.blk_count = blk_count_q;
   assign bus.upd_ready = (state_q == ST_READY);

endmodule
